// File: rtl/ps2_move_decoder_if.sv
// Bundles the keycode input, move event handshake and status lines of ps2_move_decoder.
// master = keycode source / event consumer, slave = the decoder.
interface ps2_move_decoder_if #(
    parameter int CODE_W   = 16,
    parameter int MOVE_W   = 3,
    parameter int NUM_KEYS = 5,
    parameter int LVL_W    = 3
);
    logic [CODE_W-1:0]   keycode;
    logic                move_ready;
    logic                move_valid;
    logic [MOVE_W-1:0]   move_data;
    logic [LVL_W-1:0]    fifo_level;
    logic [NUM_KEYS-1:0] key_held;
    logic                overflow;
    logic                clr_overflow;

    modport master (
        output keycode, move_ready, clr_overflow,
        input  move_valid, move_data, fifo_level, key_held, overflow
    );

    modport slave (
        input  keycode, move_ready, clr_overflow,
        output move_valid, move_data, fifo_level, key_held, overflow
    );
endinterface

// File: rtl/ps2_move_decoder.sv
// Keycode-to-move decoder: table match, hold-stable debounce, one event per press into a FWFT FIFO.
// Optional auto-repeat while a key stays held is enabled with macro KEY_AUTOREPEAT_EN.
module ps2_move_decoder #(
    parameter int                          NUM_KEYS    = 5,
    parameter int                          CODE_W      = 16,
    parameter int                          MOVE_W      = 3,
    parameter logic [NUM_KEYS*CODE_W-1:0]  KEY_CODES   = {16'hF029, 16'hF01B, 16'hF023, 16'hF01C, 16'hF01D},
    parameter logic [NUM_KEYS*MOVE_W-1:0]  MOVE_CODES  = {3'b100, 3'b010, 3'b011, 3'b001, 3'b000},
    parameter logic [MOVE_W-1:0]           IDLE_MOVE   = 3'b111,
    parameter int                          HOLD_CYCLES = 255,
    parameter int                          CNT_W       = 8,
    parameter int                          FIFO_DEPTH  = 4
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int                          REPEAT_CYCLES = 50_000_000
`endif
) (
    input  logic              CLK,
    input  logic              CPU_RESETN,
    ps2_move_decoder_if.slave bus
);
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_CYCLES);
    localparam logic [LVL_W-1:0] DEPTH_C = LVL_W'(FIFO_DEPTH);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST_C = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_FIRED} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CODE_W-1:0]   prev_q, prev_d;
    logic [NUM_KEYS-1:0] key_held_q, key_held_d;
`ifdef KEY_AUTOREPEAT_EN
    logic [CNT_W-1:0]    rcnt_q, rcnt_d;
`endif

    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                move_valid_q, move_valid_d;
    logic [MOVE_W-1:0]   move_data_q, move_data_d;
    logic                overflow_q, overflow_d;
    logic [MOVE_W-1:0]   mem_q [FIFO_DEPTH];

    logic [NUM_KEYS-1:0] match_vec;
    logic [NUM_KEYS-1:0] idx_onehot;
    logic                hit_any;
    logic [IDX_W-1:0]    hit_idx;
    logic [MOVE_W-1:0]   push_move;
    logic                cur_match;
    logic                push, pop, push_acc, ovf_set;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Table match; the first hit in index order wins so duplicate entries resolve to the lowest.
    always_comb begin
        match_vec  = '0;
        idx_onehot = '0;
        hit_any    = 1'b0;
        hit_idx    = '0;
        push_move  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match_vec[i] = (bus.keycode == prev_q) &&
                           (bus.keycode == KEY_CODES[i*CODE_W +: CODE_W]);
            if (match_vec[i] && !hit_any) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (idx_q == IDX_W'(i)) begin
                push_move     = MOVE_CODES[i*MOVE_W +: MOVE_W];
                idx_onehot[i] = 1'b1;
            end
        end
        cur_match = |(match_vec & idx_onehot);
        prev_d    = bus.keycode;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        key_held_d = key_held_q;
        push       = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_d     = rcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hit_any) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_W'(1);
                    idx_d   = hit_idx;
                end
            end
            ST_COUNT: begin
                if (!cur_match) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= HOLD_C) begin
                    push       = 1'b1;
                    state_d    = ST_FIRED;
                    key_held_d = idx_onehot;
`ifdef KEY_AUTOREPEAT_EN
                    rcnt_d     = '0;
`endif
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIRED: begin
                if (!cur_match) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    key_held_d = '0;
`ifdef KEY_AUTOREPEAT_EN
                end else if (rcnt_q == REP_LAST_C) begin
                    push   = 1'b1;
                    rcnt_d = '0;
                end else if (rcnt_q != '1) begin
                    rcnt_d = rcnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A push into a full FIFO survives only if the head leaves in the same cycle.
    always_comb begin
        pop          = move_valid_q && bus.move_ready;
        push_acc     = push && ((level_q != DEPTH_C) || pop);
        ovf_set      = push && !push_acc;
        wr_ptr_d     = push_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d      = level_q + LVL_W'(push_acc) - LVL_W'(pop);
        move_valid_d = (level_d != '0);
        move_data_d  = IDLE_MOVE;
        if (level_d != '0) begin
            move_data_d = (push_acc && (wr_ptr_q == rd_ptr_d)) ? push_move : mem_q[rd_ptr_d];
        end
        overflow_d = ovf_set ? 1'b1 : (bus.clr_overflow ? 1'b0 : overflow_q);
    end

    always_ff @(posedge CLK) begin
        if (!CPU_RESETN) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            prev_q       <= '0;
            key_held_q   <= '0;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_q       <= '0;
`endif
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            move_valid_q <= 1'b0;
            move_data_q  <= IDLE_MOVE;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            prev_q       <= prev_d;
            key_held_q   <= key_held_d;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_q       <= rcnt_d;
`endif
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            move_valid_q <= move_valid_d;
            move_data_q  <= move_data_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_move;
        end
    end

    assign bus.move_valid = move_valid_q;
    assign bus.move_data  = move_data_q;
    assign bus.fifo_level = level_q;
    assign bus.key_held   = key_held_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed plus randomized bench for ps2_move_decoder against a run-length/queue reference model.
module tb_ps2_move_decoder;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;
    localparam int REP   = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ps2_move_decoder_if #(.CODE_W(16), .MOVE_W(3), .NUM_KEYS(5), .LVL_W(3)) bus ();

    ps2_move_decoder #(
        .HOLD_CYCLES(HOLD),
        .CNT_W(8),
        .FIFO_DEPTH(DEPTH)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_CYCLES(REP)
`endif
    ) dut (
        .CLK(clk),
        .CPU_RESETN(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: key table, run length of the sampled code, event queue.
    logic [15:0] tab_code [5] = '{16'hF01D, 16'hF01C, 16'hF023, 16'hF01B, 16'hF029};
    logic [2:0]  tab_move [5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100};
    logic [15:0] last_code;
    int          run;
    logic [2:0]  mq [$];
    logic        m_ovf;
    logic [4:0]  m_held;

    function automatic int lookup(input logic [15:0] k);
        for (int i = 0; i < 5; i++) if (tab_code[i] == k) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("move_valid", 16'(bus.move_valid), 16'(mq.size() > 0));
        chk("move_data", 16'(bus.move_data), (mq.size() > 0) ? 16'(mq[0]) : 16'h7);
        chk("fifo_level", 16'(bus.fifo_level), 16'(mq.size()));
        chk("key_held", 16'(bus.key_held), 16'(m_held));
        chk("overflow", 16'(bus.overflow), 16'(m_ovf));
    endtask

    task automatic model_edge(input logic [15:0] k, input logic rdy, input logic clr);
        bit pop, ev, oset;
        int idx;
        pop  = (mq.size() > 0) && rdy;
        idx  = lookup(k);
        ev   = 1'b0;
        oset = 1'b0;
        if (k == last_code) run++; else run = 1;
        last_code = k;
        m_held = (idx >= 0 && run >= HOLD + 2) ? 5'(1 << idx) : 5'd0;
        if (idx >= 0 && run == HOLD + 2) ev = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
        if (idx >= 0 && run > HOLD + 2 && ((run - HOLD - 2) % REP) == 0) ev = 1'b1;
`endif
        if (pop) void'(mq.pop_front());
        if (ev) begin
            if (mq.size() < DEPTH) mq.push_back(tab_move[idx]);
            else oset = 1'b1;
        end
        m_ovf = oset ? 1'b1 : (clr ? 1'b0 : m_ovf);
    endtask

    task automatic step(input logic [15:0] k, input logic rdy, input logic clr);
        bus.keycode      = k;
        bus.move_ready   = rdy;
        bus.clr_overflow = clr;
        @(posedge clk);
        model_edge(k, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [15:0] k, input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(k, rdy, 1'b0);
    endtask

    task automatic do_reset(input logic [15:0] k);
        rst_n       = 1'b0;
        bus.keycode = k;
        @(posedge clk);
        mq.delete();
        m_ovf     = 1'b0;
        m_held    = '0;
        run       = 0;
        last_code = '0;
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.keycode      = '0;
        bus.move_ready   = 1'b1;
        bus.clr_overflow = 1'b0;
        rst_n            = 1'b0;
        do_reset(16'h0);
        do_reset(16'h0);

        // Single press, then release
        hold(16'hF01D, 10, 1'b1);
        hold(16'h0000, 3, 1'b1);

        // Short F01C then long F023: only F023 fires
        hold(16'hF01C, 3, 1'b1);
        hold(16'hF023, 10, 1'b1);
        hold(16'h0000, 3, 1'b1);

        // Five presses with consumer stalled, then drain
        for (int p = 0; p < 5; p++) begin
            hold(tab_code[p], HOLD + 2, 1'b0);
            hold(16'h0000, 1, 1'b0);
        end
        chk("level_full", 16'(bus.fifo_level), 16'd4);
        chk("ovf_after_5", 16'(bus.overflow), 16'd1);
        hold(16'h0000, 6, 1'b1);
        step(16'h0000, 1'b1, 1'b1);
        chk("ovf_cleared", 16'(bus.overflow), 16'd0);

        // Full FIFO, push and pop on the same edge
        for (int p = 0; p < 4; p++) begin
            hold(tab_code[4 - p], HOLD + 2, 1'b0);
            hold(16'h0000, 1, 1'b0);
        end
        hold(16'hF01C, HOLD + 1, 1'b0);
        step(16'hF01C, 1'b1, 1'b0);
        chk("full_pushpop_level", 16'(bus.fifo_level), 16'd4);
        chk("full_pushpop_ovf", 16'(bus.overflow), 16'd0);
        hold(16'h0000, 7, 1'b1);

        // Reset in the middle of a count
        hold(16'hF029, 4, 1'b1);
        do_reset(16'h0);
        hold(16'h0000, 8, 1'b1);

`ifdef KEY_AUTOREPEAT_EN
        hold(16'hF01B, 30, 1'b1);
        hold(16'h0000, 3, 1'b1);
`endif

        // Randomized presses, stalls and overflow clears
        for (int s = 0; s < 60; s++) begin
            logic [15:0] k;
            int          len;
            k   = ($urandom_range(0, 9) < 8) ? tab_code[$urandom_range(0, 4)] : 16'($urandom);
            len = $urandom_range(1, 9);
            for (int c = 0; c < len; c++)
                step(k, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
        end
        hold(16'h0000, 8, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
